pa_out_dma: RTL and testbench

DMA-fed parallel output port: the transmit-side counterpart of the DMA parallel-input capture block. The CPU or a DMA channel writes bytes over the system bus into FIFO0 of a single 8-bit UDB datapath. The block pops each byte into A0, drives it on the parallel output `po`, and holds it under a valid/ready handshake until the downstream logic accepts it. It requests DMA whenever FIFO0 has room, and it flags underrun when a stream runs dry.

---
 rtl/pa_out_dma.sv | 133 +++++++++++++
 tb/tb_pa_out_dma.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_out_dma.sv
// pa_out_dma: DMA-fed parallel output port.
// Bytes written over the bus land in a 4-deep FIFO0, are popped one at a
// time into A0 and presented on po under a valid/ready handshake.
module pa_out_dma #(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       ready,
    input  logic       bus_wr,
    input  logic [7:0] bus_data,
    output logic [7:0] po,
    output logic       po_valid,
    output logic       dma,
    output logic       underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        SHOW = 2'b10,
        GAP  = 2'b11
    } state_t;

    localparam bit         HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_RELOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t      state;
    logic [2:0]  cs_addr;
    logic [3:0]  gap_cnt;

    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  level;

    logic        f0_blk_stat;
    logic        f0_bus_stat;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        resume;
    logic [7:0]  f0_head;

    // The FSM state selects the datapath configuration; address 001 is the A0 <- F0 load.
    assign cs_addr     = {1'b0, state};

    assign fifo_full   = (level == 3'd4);
    assign f0_blk_stat = (level == 3'd0);
    assign f0_bus_stat = !fifo_full;
    assign dma         = f0_bus_stat;

    // Writes while FIFO0 is full are silently dropped.
    assign push    = bus_wr && !fifo_full;
    assign pop     = (cs_addr == 3'b001) && !f0_blk_stat;
    assign f0_head = fifo_mem[rd_ptr];
    assign resume  = enable && !f0_blk_stat;

    // FIFO0 storage: bus side writes, datapath side pops during LOAD.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 8'h00;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            level  <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            level <= level + 3'(push) - 3'(pop);
        end
    end

    // Output FSM with A0, po_valid, gap counter and sticky underrun all registered together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            po       <= 8'h00;
            po_valid <= 1'b0;
            gap_cnt  <= 4'd0;
            underrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (resume) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    po       <= f0_head;
                    po_valid <= 1'b1;
                    state    <= SHOW;
                end
                SHOW: begin
                    if (ready) begin
                        po_valid <= 1'b0;
                        if (HAS_GAP) begin
                            state   <= GAP;
                            gap_cnt <= GAP_RELOAD;
                        end else begin
                            state <= resume ? LOAD : IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= resume ? LOAD : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Clearing on a low enable takes priority over setting on an empty accept.
            if (!enable) begin
                underrun <= 1'b0;
            end else if ((state == SHOW) && ready && f0_blk_stat) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pa_out_dma.sv
// tb_pa_out_dma: scoreboard bench for pa_out_dma.
// Written bytes are queued as expected output; a negedge monitor compares
// every presented/accepted byte against the queue head.
module tb_pa_out_dma;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable, ready, bus_wr;
    logic [7:0] bus_data;
    logic [7:0] po;
    logic       po_valid, dma, underrun;

    logic       g_enable, g_ready, g_wr;
    logic [7:0] g_data;
    logic [7:0] g_po;
    logic       g_po_valid, g_dma, g_underrun;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_count = 0;
    int acc_cyc[$];
    logic [7:0] exp_q[$];

    pa_out_dma #(.GAP_CYCLES(0)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .ready(ready),
        .bus_wr(bus_wr), .bus_data(bus_data), .po(po), .po_valid(po_valid),
        .dma(dma), .underrun(underrun)
    );

    pa_out_dma #(.GAP_CYCLES(3)) dut_gap (
        .clock(clock), .reset_n(reset_n), .enable(g_enable), .ready(g_ready),
        .bus_wr(g_wr), .bus_data(g_data), .po(g_po), .po_valid(g_po_valid),
        .dma(g_dma), .underrun(g_underrun)
    );

    always #5 clock = ~clock;

    // Free-running cycle count used to time output pulses.
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: a valid byte must match the queue head; an accept retires it.
    initial forever begin
        @(negedge clock);
        if (reset_n && po_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no valid byte", po);
            end else if (ready) begin
                checkOutput("accept_data", int'(po), int'(exp_q.pop_front()));
                acc_count++;
                acc_cyc.push_back(cyc);
            end else begin
                checkOutput("held_data", int'(po), int'(exp_q[0]));
            end
        end
    end

    // Source honours dma: wait for room, then write one byte and expect it out later.
    task automatic applyStimulus(input logic [7:0] b);
        int budget = 300;
        while (!dma && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        if (!dma) begin
            tests++;
            fails++;
            $display("[TB] FAIL dma_wait: got dma=0 after budget, expected dma=1");
        end else begin
            bus_wr   = 1'b1;
            bus_data = b;
            exp_q.push_back(b);
            @(posedge clock); #1;
            bus_wr = 1'b0;
        end
    endtask

    task automatic waitAccepts(input int n, input string name);
        int budget = 400;
        while (acc_count < n && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        if (acc_count < n) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: got %0d accepts, expected %0d", name, acc_count, n);
        end
    endtask

    task automatic waitValid(input string name);
        int budget = 50;
        while (!po_valid && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        if (!po_valid) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: got po_valid=0, expected 1", name);
        end
    endtask

    // Hard stop so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        bit done;
        int rise_cyc[$];
        logic [7:0] rise_po[$];
        logic prev;

        reset_n = 1'b0; enable = 1'b0; ready = 1'b0; bus_wr = 1'b0; bus_data = 8'h00;
        g_enable = 1'b0; g_ready = 1'b0; g_wr = 1'b0; g_data = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // Reset and idle with nothing queued.
        checkOutput("reset_po", po, 8'h00);
        checkOutput("reset_valid", po_valid, 0);
        checkOutput("reset_underrun", underrun, 0);
        checkOutput("reset_dma", dma, 1);
        checkOutput("reset_gap_dma", g_dma, 1);
        enable = 1'b1;
        repeat (4) begin @(posedge clock); #1; end
        checkOutput("idle_no_data", po_valid, 0);
        enable = 1'b0;

        // Burst of four with ready high.
        ready = 1'b1;
        applyStimulus(8'hFF); applyStimulus(8'hF0); applyStimulus(8'hCC); applyStimulus(8'hAA);
        checkOutput("dma_full", dma, 0);
        acc_cyc.delete();
        base = acc_count;
        enable = 1'b1;
        @(posedge clock); #1;
        checkOutput("dma_before_pop", dma, 0);
        @(posedge clock); #1;
        checkOutput("dma_after_pop", dma, 1);
        checkOutput("first_latency", po_valid, 1);
        waitAccepts(base + 3, "burst_accepts3");
        checkOutput("underrun_early", underrun, 0);
        waitAccepts(base + 4, "burst_accepts4");
        checkOutput("underrun_set", underrun, 1);
        if (acc_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++) checkOutput("burst_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
        end
        enable = 1'b0;
        @(posedge clock); #1;
        checkOutput("underrun_clear", underrun, 0);

        // Backpressure on 0x55.
        ready = 1'b0; enable = 1'b1;
        base = acc_count;
        applyStimulus(8'h55); applyStimulus(8'h66);
        waitValid("bp_valid");
        repeat (5) begin
            checkOutput("bp_hold_valid", po_valid, 1);
            checkOutput("bp_hold_data", po, 8'h55);
            @(posedge clock); #1;
        end
        ready = 1'b1;
        @(posedge clock); #1;
        checkOutput("bp_release_gap", po_valid, 0);
        @(posedge clock); #1;
        checkOutput("bp_next_valid", po_valid, 1);
        checkOutput("bp_next_data", po, 8'h66);
        waitAccepts(base + 2, "bp_accepts");
        enable = 1'b0;
        @(posedge clock); #1;

        // Disable while presenting, with two bytes still queued.
        ready = 1'b0; enable = 1'b1;
        base = acc_count;
        applyStimulus(8'hA1); applyStimulus(8'hA2); applyStimulus(8'hA3);
        waitValid("dis_valid");
        enable = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        checkOutput("dis_hold_valid", po_valid, 1);
        checkOutput("dis_hold_data", po, 8'hA1);
        ready = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        ready = 1'b0;
        checkOutput("dis_idle", po_valid, 0);
        checkOutput("dis_po_retained", po, 8'hA1);
        checkOutput("dis_underrun", underrun, 0);
        checkOutput("dis_dma_room", dma, 1);
        applyStimulus(8'hB1); applyStimulus(8'hB2);
        checkOutput("dis_fifo_kept", dma, 0);
        enable = 1'b1; ready = 1'b1;
        waitAccepts(base + 5, "dis_resume");
        enable = 1'b0;
        @(posedge clock); #1;

        // Randomised traffic with random enable and backpressure.
        base = acc_count;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
                    applyStimulus(8'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ready  = ($urandom_range(0, 9) < 7);
                    enable = ($urandom_range(0, 9) < 8);
                    @(posedge clock); #1;
                end
            end
        join
        enable = 1'b1; ready = 1'b1;
        waitAccepts(base + 120, "random_accepts");
        checkOutput("random_drain", exp_q.size(), 0);
        repeat (3) begin @(posedge clock); #1; end
        checkOutput("random_idle", po_valid, 0);
        enable = 1'b0;

        // Gap of three idle clocks between bytes.
        g_ready = 1'b1;
        g_wr = 1'b1; g_data = 8'h3C;
        @(posedge clock); #1;
        g_data = 8'hC3;
        @(posedge clock); #1;
        g_wr = 1'b0;
        g_enable = 1'b1;
        prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (g_po_valid && !prev) begin
                rise_cyc.push_back(cyc);
                rise_po.push_back(g_po);
            end
            prev = g_po_valid;
        end
        checkOutput("gap_pulses", rise_cyc.size(), 2);
        if (rise_cyc.size() == 2) begin
            checkOutput("gap_spacing", rise_cyc[1] - rise_cyc[0], 5);
            checkOutput("gap_first_data", rise_po[0], 8'h3C);
            checkOutput("gap_second_data", rise_po[1], 8'hC3);
        end
        checkOutput("gap_underrun", g_underrun, 1);
        g_enable = 1'b0;
        @(posedge clock); #1;

        // Asynchronous reset while a byte is presented.
        ready = 1'b0; enable = 1'b1;
        applyStimulus(8'h99);
        waitValid("rst_valid");
        #1;
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", po_valid, 0);
        checkOutput("rst_async_po", po, 8'h00);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        checkOutput("rst_dma", dma, 1);
        repeat (4) begin @(posedge clock); #1; end
        checkOutput("rst_fifo_empty", po_valid, 0);
        checkOutput("rst_underrun", underrun, 0);
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
